vector_floating_point_multiply_sequencer: RTL

Controls the vector floating-point multiply unit for one vector multiply instruction. It walks the source register group 64 bits at a time, reads operands from the vector register file, and presents them to the multiply unit. It then writes back the product, which is one 64-bit word in normal mode or two in widening mode. It sits between the issue stage (start handshake) and the vector register file (read port plus writeback handshake).

---
 rtl/vector_floating_point_multiply_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vector_floating_point_multiply_sequencer.sv
// Sequences one vector FP multiply: read a 64-bit chunk pair, multiply, write back one or two words.
// Execution vector layout: [2:1] bit_mode (1 = 64-bit, 2 = 32-bit, others illegal), [0] widening_mode.
module vector_floating_point_multiply_sequencer #(
  parameter int MAX_CHUNKS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [2:0]                     start_execution_vector,
  input  logic [4:0]                     start_vs2_index,
  input  logic [4:0]                     start_vs1_index,
  input  logic [4:0]                     start_vd_index,
  input  logic [$clog2(MAX_CHUNKS):0]    start_chunk_count,
  output logic                           rf_read_enable,
  output logic [4:0]                     rf_read_vs2_index,
  output logic [4:0]                     rf_read_vs1_index,
  output logic [$clog2(MAX_CHUNKS)-1:0]  rf_read_chunk,
  input  logic [63:0]                    rf_read_vs2_data,
  input  logic [63:0]                    rf_read_vs1_data,
  output logic [2:0]                     mul_execution_vector,
  output logic [63:0]                    mul_vs2,
  output logic [63:0]                    mul_vs1,
  input  logic [63:0]                    mul_vd,
  input  logic [63:0]                    mul_vd_high,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [4:0]                     wb_register_index,
  output logic [$clog2(MAX_CHUNKS):0]    wb_chunk,
  output logic [63:0]                    wb_data,
  output logic                           done,
  output logic                           error
);
  localparam int CW = $clog2(MAX_CHUNKS);
  localparam logic [1:0] ENABLED_64BIT_MODE    = 2'd1;
  localparam logic [1:0] ENABLED_32BIT_MODE    = 2'd2;
  localparam logic       ENABLED_WIDENING_MODE = 1'b1;
  localparam logic [CW:0]   COUNT_ONE = 1;
  localparam logic [CW-1:0] CHUNK_ONE = 1;

  typedef enum logic [2:0] {IDLE, READ, EXECUTE, WRITE_LOW, WRITE_HIGH, DONE} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    ev_reg, ev_next;
  logic [4:0]    vs2_idx_reg, vs2_idx_next;
  logic [4:0]    vs1_idx_reg, vs1_idx_next;
  logic [4:0]    vd_idx_reg, vd_idx_next;
  logic [CW:0]   count_reg, count_next;
  logic [CW-1:0] chunk_reg, chunk_next;
  logic [63:0]   result_low_reg, result_low_next;
  logic [63:0]   result_high_reg, result_high_next;
  logic          error_reg, error_next;
  logic          widening;
  logic          last_chunk;
  logic          start_legal;

  // Widening only has meaning for 32-bit elements; 64-bit mode ignores the flag.
  assign widening    = (ev_reg[2:1] == ENABLED_32BIT_MODE) && (ev_reg[0] == ENABLED_WIDENING_MODE);
  assign last_chunk  = ({1'b0, chunk_reg} == (count_reg - COUNT_ONE));
  assign start_legal = (start_execution_vector[2:1] == ENABLED_64BIT_MODE) ||
                       (start_execution_vector[2:1] == ENABLED_32BIT_MODE);
  assign mul_execution_vector = ev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ev_reg          <= '0;
      vs2_idx_reg     <= '0;
      vs1_idx_reg     <= '0;
      vd_idx_reg      <= '0;
      count_reg       <= '0;
      chunk_reg       <= '0;
      result_low_reg  <= '0;
      result_high_reg <= '0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ev_reg          <= ev_next;
      vs2_idx_reg     <= vs2_idx_next;
      vs1_idx_reg     <= vs1_idx_next;
      vd_idx_reg      <= vd_idx_next;
      count_reg       <= count_next;
      chunk_reg       <= chunk_next;
      result_low_reg  <= result_low_next;
      result_high_reg <= result_high_next;
      error_reg       <= error_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ev_next           = ev_reg;
    vs2_idx_next      = vs2_idx_reg;
    vs1_idx_next      = vs1_idx_reg;
    vd_idx_next       = vd_idx_reg;
    count_next        = count_reg;
    chunk_next        = chunk_reg;
    result_low_next   = result_low_reg;
    result_high_next  = result_high_reg;
    error_next        = error_reg;
    start_ready       = 1'b0;
    rf_read_enable    = 1'b0;
    rf_read_vs2_index = '0;
    rf_read_vs1_index = '0;
    rf_read_chunk     = '0;
    mul_vs2           = '0;
    mul_vs1           = '0;
    wb_valid          = 1'b0;
    wb_register_index = '0;
    wb_chunk          = '0;
    wb_data           = '0;
    done              = 1'b0;
    error             = 1'b0;

    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          ev_next      = start_execution_vector;
          vs2_idx_next = start_vs2_index;
          vs1_idx_next = start_vs1_index;
          vd_idx_next  = start_vd_index;
          count_next   = start_chunk_count;
          chunk_next   = '0;
          error_next   = !start_legal;
          state_next   = (!start_legal || start_chunk_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        rf_read_enable    = 1'b1;
        rf_read_vs2_index = vs2_idx_reg;
        rf_read_vs1_index = vs1_idx_reg;
        rf_read_chunk     = chunk_reg;
        state_next        = EXECUTE;
      end
      EXECUTE: begin
        mul_vs2          = rf_read_vs2_data;
        mul_vs1          = rf_read_vs1_data;
        result_low_next  = mul_vd;
        result_high_next = mul_vd_high;
        state_next       = WRITE_LOW;
      end
      WRITE_LOW, WRITE_HIGH: begin
        wb_valid          = 1'b1;
        wb_register_index = vd_idx_reg;
        if (state_reg == WRITE_HIGH) begin
          wb_data  = result_high_reg;
          wb_chunk = {chunk_reg, 1'b1};
        end else begin
          wb_data  = result_low_reg;
          wb_chunk = widening ? {chunk_reg, 1'b0} : {1'b0, chunk_reg};
        end
        if (wb_ready) begin
          if (state_reg == WRITE_LOW && widening) begin
            state_next = WRITE_HIGH;
          end else if (last_chunk) begin
            state_next = DONE;
          end else begin
            chunk_next = chunk_reg + CHUNK_ONE;
            state_next = READ;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        error      = error_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
